// File: rtl/ghost_mode_scheduler_if.sv
// Ghost-mode type shared by the scheduler and the per-ghost FSMs, plus the
// scheduler's control/status bundle.
package ghost_mode_pkg;
  typedef enum logic [1:0] {
    SCATTER = 2'd0,
    CHASE   = 2'd1,
    AFFRAID = 2'd2,
    EATEN   = 2'd3
  } ghost_modes_t;
endpackage

interface ghost_mode_scheduler_if;
  import ghost_mode_pkg::*;

  logic         restart;
  logic         tick;
  logic         pause;
  logic         big_gum_eat;
  ghost_modes_t general_state;
  ghost_modes_t old_general_state;
  logic         twinkle;
  logic         mode_change;
  logic [2:0]   phase_idx;

  modport master (
    output restart, tick, pause, big_gum_eat,
    input  general_state, old_general_state, twinkle, mode_change, phase_idx
  );

  modport slave (
    input  restart, tick, pause, big_gum_eat,
    output general_state, old_general_state, twinkle, mode_change, phase_idx
  );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Global ghost-mode sequencer: SCATTER/CHASE timetable pre-empted by AFFRAID
// after a big gum, with shared end-of-fright twinkle and reversal pulse.
module ghost_mode_scheduler
  import ghost_mode_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int SCATTER_T0    = 70,
  parameter int SCATTER_T1    = 70,
  parameter int SCATTER_T2    = 50,
  parameter int SCATTER_T3    = 50,
  parameter int CHASE_T       = 200,
  parameter int FRIGHT_T      = 60,
  parameter int TWINKLE_START = 20,
  parameter int TWINKLE_HALF  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  ghost_mode_scheduler_if.slave bus
);

  typedef enum logic {SCHED, FRIGHT} sched_state_t;

  localparam logic [CNT_W-1:0] ONE_V       = CNT_W'(1);
  localparam logic [CNT_W-1:0] SCATTER_V0  = CNT_W'(SCATTER_T0);
  localparam logic [CNT_W-1:0] SCATTER_V1  = CNT_W'(SCATTER_T1);
  localparam logic [CNT_W-1:0] SCATTER_V2  = CNT_W'(SCATTER_T2);
  localparam logic [CNT_W-1:0] SCATTER_V3  = CNT_W'(SCATTER_T3);
  localparam logic [CNT_W-1:0] CHASE_V     = CNT_W'(CHASE_T);
  localparam logic [CNT_W-1:0] FRIGHT_V    = CNT_W'(FRIGHT_T);
  localparam logic [CNT_W-1:0] TWK_START_V = CNT_W'(TWINKLE_START);
  localparam logic [CNT_W-1:0] TWK_HALF_V  = CNT_W'(TWINKLE_HALF);

  sched_state_t     state;
  ghost_modes_t     gen_q;
  ghost_modes_t     old_q;
  logic [2:0]       phase_q;
  logic [2:0]       phase_nxt;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] fright_cnt;
  logic [CNT_W-1:0] fright_nxt;
  logic [CNT_W-1:0] half_cnt;
  logic             twinkle_q;
  logic             mode_change_q;

  // Phase 7 has no duration: its timer is never decremented.
  function automatic logic [CNT_W-1:0] phase_len(input logic [2:0] p);
    case (p)
      3'd0:             phase_len = SCATTER_V0;
      3'd2:             phase_len = SCATTER_V1;
      3'd4:             phase_len = SCATTER_V2;
      3'd6:             phase_len = SCATTER_V3;
      3'd1, 3'd3, 3'd5: phase_len = CHASE_V;
      default:          phase_len = '0;
    endcase
  endfunction

  function automatic ghost_modes_t phase_mode(input logic [2:0] p);
    return p[0] ? CHASE : SCATTER;
  endfunction

  assign phase_nxt  = phase_q + 3'd1;
  assign fright_nxt = fright_cnt - ONE_V;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SCHED;
      gen_q         <= SCATTER;
      old_q         <= SCATTER;
      phase_q       <= 3'd0;
      phase_cnt     <= SCATTER_V0;
      fright_cnt    <= '0;
      half_cnt      <= '0;
      twinkle_q     <= 1'b0;
      mode_change_q <= 1'b0;
    end else if (bus.restart) begin
      state         <= SCHED;
      gen_q         <= SCATTER;
      old_q         <= SCATTER;
      phase_q       <= 3'd0;
      phase_cnt     <= SCATTER_V0;
      fright_cnt    <= '0;
      half_cnt      <= '0;
      twinkle_q     <= 1'b0;
      mode_change_q <= 1'b0;
    end else begin
      mode_change_q <= 1'b0;
      // While paused everything holds; tick and big_gum_eat are simply lost.
      if (!bus.pause) begin
        case (state)
          SCHED: begin
            if (bus.big_gum_eat) begin
              state         <= FRIGHT;
              gen_q         <= AFFRAID;
              fright_cnt    <= FRIGHT_V;
              twinkle_q     <= 1'b0;
              mode_change_q <= 1'b1;
            end else if (bus.tick && phase_q != 3'd7) begin
              if (phase_cnt == ONE_V) begin
                phase_q       <= phase_nxt;
                phase_cnt     <= phase_len(phase_nxt);
                gen_q         <= phase_mode(phase_nxt);
                old_q         <= phase_mode(phase_nxt);
                mode_change_q <= 1'b1;
              end else begin
                phase_cnt <= phase_cnt - ONE_V;
              end
            end
          end
          FRIGHT: begin
            if (bus.big_gum_eat) begin
              fright_cnt <= FRIGHT_V;
              twinkle_q  <= 1'b0;
            end else if (bus.tick) begin
              if (fright_cnt == ONE_V) begin
                state         <= SCHED;
                gen_q         <= old_q;
                fright_cnt    <= '0;
                twinkle_q     <= 1'b0;
                mode_change_q <= 1'b1;
              end else begin
                fright_cnt <= fright_nxt;
                // Twinkle window opens when the remaining time hits TWINKLE_START.
                if (fright_nxt == TWK_START_V) begin
                  twinkle_q <= 1'b1;
                  half_cnt  <= TWK_HALF_V;
                end else if (fright_nxt < TWK_START_V) begin
                  if (half_cnt == ONE_V) begin
                    twinkle_q <= ~twinkle_q;
                    half_cnt  <= TWK_HALF_V;
                  end else begin
                    half_cnt <= half_cnt - ONE_V;
                  end
                end
              end
            end
          end
          default: state <= SCHED;
        endcase
      end
    end
  end

  assign bus.general_state     = gen_q;
  assign bus.old_general_state = old_q;
  assign bus.twinkle           = twinkle_q;
  assign bus.mode_change       = mode_change_q;
  assign bus.phase_idx         = phase_q;

endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Directed bench for ghost_mode_scheduler: timetable, fright, twinkle,
// restart and pause scenarios with hand-computed expectations.
module tb_ghost_mode_scheduler;
  import ghost_mode_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   mc_count = 0;
  int   exp_mc = 0;

  ghost_mode_scheduler_if bus();

  ghost_mode_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mode_change === 1'b1) mc_count <= mc_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes, then settle just past the following falling edge.
  task automatic step(input logic t, input logic g);
    @(negedge clk);
    bus.tick        = t;
    bus.big_gum_eat = g;
    @(negedge clk);
    bus.tick        = 1'b0;
    bus.big_gum_eat = 1'b0;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  function automatic logic twk_exp(input int k);
    if (k < 40) return 1'b0;
    return (((k - 40) / 2) % 2) == 0;
  endfunction

  // Runs fright ticks 1..59 checking AFFRAID and the twinkle pattern.
  task automatic fright_body(input string tag);
    for (int k = 1; k <= 59; k++) begin
      step(1'b1, 1'b0);
      check({tag, "_affraid"}, 32'(bus.general_state), 32'(AFFRAID));
      check({tag, "_twinkle"}, 32'(bus.twinkle), 32'(twk_exp(k)));
    end
  endtask

  initial begin
    int durs[6];
    durs = '{200, 70, 200, 50, 200, 50};
    bus.restart     = 1'b0;
    bus.tick        = 1'b0;
    bus.pause       = 1'b0;
    bus.big_gum_eat = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_gen",   32'(bus.general_state),     32'(SCATTER));
    check("rst_old",   32'(bus.old_general_state), 32'(SCATTER));
    check("rst_phase", 32'(bus.phase_idx),         32'd0);
    check("rst_twk",   32'(bus.twinkle),           32'd0);
    check("rst_mc",    32'(bus.mode_change),       32'd0);

    // Phase 0 lasts 70 ticks.
    for (int i = 1; i <= 69; i++) begin
      step(1'b1, 1'b0);
      check("p0_scatter", 32'(bus.general_state), 32'(SCATTER));
    end
    check("p0_nomc", 32'(mc_count), 32'(exp_mc));
    step(1'b1, 1'b0);
    exp_mc++;
    check("p1_gen",    32'(bus.general_state),     32'(CHASE));
    check("p1_old",    32'(bus.old_general_state), 32'(CHASE));
    check("p1_phase",  32'(bus.phase_idx),         32'd1);
    check("p1_mcpulse", 32'(bus.mode_change),      32'd1);
    check("p1_mc",     32'(mc_count),              32'(exp_mc));

    // Big gum with 30 ticks of phase 1 left.
    ticks(170);
    step(1'b0, 1'b1);
    exp_mc++;
    check("f1_gen", 32'(bus.general_state),     32'(AFFRAID));
    check("f1_old", 32'(bus.old_general_state), 32'(CHASE));
    check("f1_mc",  32'(mc_count),              32'(exp_mc));
    fright_body("f1");
    check("f1_old_hold", 32'(bus.old_general_state), 32'(CHASE));
    step(1'b1, 1'b0);
    exp_mc++;
    check("f1_exit_gen", 32'(bus.general_state), 32'(CHASE));
    check("f1_exit_twk", 32'(bus.twinkle),       32'd0);
    check("f1_exit_mc",  32'(mc_count),          32'(exp_mc));
    ticks(29);
    check("f1_resume_phase", 32'(bus.phase_idx), 32'd1);
    step(1'b1, 1'b0);
    exp_mc++;
    check("p2_phase", 32'(bus.phase_idx),     32'd2);
    check("p2_gen",   32'(bus.general_state), 32'(SCATTER));
    check("p2_mc",    32'(mc_count),          32'(exp_mc));

    // Reload at fright tick 50: total AFFRAID 110 ticks.
    step(1'b0, 1'b1);
    exp_mc++;
    for (int k = 1; k <= 50; k++) begin
      step(1'b1, 1'b0);
      check("f2a_twinkle", 32'(bus.twinkle), 32'(twk_exp(k)));
    end
    check("f2a_twk48", 32'(twk_exp(48)), 32'd1);
    step(1'b0, 1'b1);
    check("f2_reload_gen", 32'(bus.general_state), 32'(AFFRAID));
    check("f2_reload_twk", 32'(bus.twinkle),       32'd0);
    check("f2_reload_mc",  32'(mc_count),          32'(exp_mc));
    fright_body("f2b");
    step(1'b1, 1'b0);
    exp_mc++;
    check("f2_exit_gen", 32'(bus.general_state), 32'(SCATTER));
    check("f2_exit_mc",  32'(mc_count),          32'(exp_mc));

    // Big gum coincident with the final fright tick.
    step(1'b0, 1'b1);
    exp_mc++;
    fright_body("f3a");
    step(1'b1, 1'b1);
    check("f3_same_gen", 32'(bus.general_state), 32'(AFFRAID));
    check("f3_same_twk", 32'(bus.twinkle),       32'd0);
    check("f3_same_mc",  32'(mc_count),          32'(exp_mc));
    fright_body("f3b");
    step(1'b1, 1'b0);
    exp_mc++;
    check("f3_exit_gen", 32'(bus.general_state), 32'(SCATTER));
    check("f3_exit_mc",  32'(mc_count),          32'(exp_mc));

    // Phase 2 timer was frozen at 70 throughout.
    ticks(70);
    exp_mc++;
    check("p3_phase", 32'(bus.phase_idx),     32'd3);
    check("p3_gen",   32'(bus.general_state), 32'(CHASE));

    // Restart in the middle of a fright during phase 3.
    ticks(10);
    step(1'b0, 1'b1);
    exp_mc++;
    ticks(45);
    check("f4_twk45", 32'(bus.twinkle), 32'd1);
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    #1;
    check("rs_gen",   32'(bus.general_state),     32'(SCATTER));
    check("rs_old",   32'(bus.old_general_state), 32'(SCATTER));
    check("rs_phase", 32'(bus.phase_idx),         32'd0);
    check("rs_twk",   32'(bus.twinkle),           32'd0);
    check("rs_mc",    32'(mc_count),              32'(exp_mc));

    // Pause one tick before phase 0 would expire.
    ticks(69);
    bus.pause = 1'b1;
    ticks(100);
    step(1'b0, 1'b1);
    check("pz_gen",   32'(bus.general_state), 32'(SCATTER));
    check("pz_phase", 32'(bus.phase_idx),     32'd0);
    check("pz_mc",    32'(mc_count),          32'(exp_mc));
    bus.pause = 1'b0;
    step(1'b1, 1'b0);
    exp_mc++;
    check("pz_resume_gen",   32'(bus.general_state), 32'(CHASE));
    check("pz_resume_phase", 32'(bus.phase_idx),     32'd1);

    // Remaining timetable up to the unbounded phase 7.
    for (int i = 0; i < 6; i++) begin
      ticks(durs[i]);
      exp_mc++;
      check("tt_phase", 32'(bus.phase_idx),     32'(i + 2));
      check("tt_gen",   32'(bus.general_state), (i % 2 == 0) ? 32'(SCATTER) : 32'(CHASE));
    end
    check("tt_mc", 32'(mc_count), 32'(exp_mc));
    ticks(2000);
    check("p7_gen",   32'(bus.general_state), 32'(CHASE));
    check("p7_phase", 32'(bus.phase_idx),     32'd7);
    check("p7_mc",    32'(mc_count),          32'(exp_mc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
